// File: rtl/block_scheduler_pkg.sv
// Shared types and helpers for the kernel block scheduler.
package gpu_sched_pkg;

    localparam int BLOCK_ID_W = 8;

    typedef enum logic [1:0] {K_IDLE, K_RUN, K_DONE} kernel_state_t;
    typedef enum logic       {C_IDLE, C_RUN}         core_state_t;

    // Widened to 9 bits so that 255 threads plus the rounding term cannot wrap.
    function automatic logic [BLOCK_ID_W-1:0] ceil_div_blocks(
        input logic [7:0]  threads,
        input int unsigned tpb_log2
    );
        logic [8:0] sum;
        sum = {1'b0, threads} + ((9'd1 << tpb_log2) - 9'd1);
        return BLOCK_ID_W'(sum >> tpb_log2);
    endfunction

endpackage

// File: rtl/block_scheduler_if.sv
// Kernel launch handshake between the host-facing launch logic and the scheduler.
interface block_scheduler_if;
    import gpu_sched_pkg::*;

    logic                  launch_valid;
    logic                  launch_ready;
    logic [BLOCK_ID_W-1:0] launch_thread_count;

    modport master (output launch_valid, output launch_thread_count, input launch_ready);
    modport slave  (input launch_valid, input launch_thread_count, output launch_ready);

endinterface

// File: rtl/block_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest request at or above ptr_i,
// wrapping to the lowest request overall when none lie above the pointer.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          valid_o
);

    logic [N-1:0] upper_mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick;

    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (PW'(i) >= ptr_i);
        end
        masked  = req_i & upper_mask;
        pick    = (|masked) ? masked : req_i;
        grant_o = pick & (~pick + N'(1));
        valid_o = |req_i;
    end

endmodule

// File: rtl/block_scheduler.sv
// Kernel block scheduler: splits a launched kernel into fixed-size blocks,
// dispatches them round-robin onto free cores and reports kernel completion.
//
//   state  | meaning
//   K_IDLE | no kernel in flight, launch accepted
//   K_RUN  | dispatching and retiring blocks, busy
//   K_DONE | every block retired, done held until the next launch
//   C_IDLE | core held in reset, eligible for a block
//   C_RUN  | core executing its dispatched block
module block_scheduler
    import gpu_sched_pkg::*;
#(
    parameter  int NUM_CORES         = 2,
    parameter  int THREADS_PER_BLOCK = 4,
    localparam int CW                = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    block_scheduler_if.slave                     launch,
    input  logic                                 abort,
    input  logic [NUM_CORES-1:0]                 core_done,
    output logic [NUM_CORES-1:0]                 core_start,
    output logic [NUM_CORES-1:0]                 core_reset,
    output logic [NUM_CORES-1:0][BLOCK_ID_W-1:0] core_block_id,
    output logic [NUM_CORES-1:0][CW-1:0]         core_thread_count,
    output logic                                 busy,
    output logic                                 done
);

    localparam int PW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);

    kernel_state_t kstate_q, kstate_d;
    core_state_t   cstate_q [NUM_CORES];
    core_state_t   cstate_d [NUM_CORES];

    logic [BLOCK_ID_W-1:0] thread_count_q, thread_count_d;
    logic [BLOCK_ID_W-1:0] total_q, total_d;
    logic [BLOCK_ID_W-1:0] disp_q, disp_d;
    logic [BLOCK_ID_W-1:0] ndone_q, ndone_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [NUM_CORES-1:0][BLOCK_ID_W-1:0] bid_q, bid_d;
    logic [NUM_CORES-1:0][CW-1:0]         tcnt_q, tcnt_d;

    logic [NUM_CORES-1:0]  idle_vec, retire, grant;
    logic                  grant_valid, accept, all_idle;
    logic [BLOCK_ID_W-1:0] ret_cnt;
    logic [PW-1:0]         win;
    logic [CW-1:0]         block_threads;

    always_comb begin
        idle_vec = '0;
        retire   = '0;
        ret_cnt  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idle_vec[i] = (cstate_q[i] == C_IDLE);
            retire[i]   = (cstate_q[i] == C_RUN) && core_done[i];
            ret_cnt     = ret_cnt + BLOCK_ID_W'(retire[i]);
        end
    end

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req_i   (idle_vec & ~retire),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) win = PW'(i);
        end
    end

    assign all_idle            = &idle_vec;
    assign launch.launch_ready = (kstate_q != K_RUN);
    assign accept              = launch.launch_valid && launch.launch_ready;

    // Only the final block can be partial; its size is whatever threads remain.
    assign block_threads = (disp_q == total_q - BLOCK_ID_W'(1))
                         ? CW'(thread_count_q - (disp_q << TPB_LOG2))
                         : CW'(THREADS_PER_BLOCK);

    always_comb begin
        kstate_d       = kstate_q;
        cstate_d       = cstate_q;
        thread_count_d = thread_count_q;
        total_d        = total_q;
        disp_d         = disp_q;
        ndone_d        = ndone_q;
        rr_d           = rr_q;
        bid_d          = bid_q;
        tcnt_d         = tcnt_q;
        case (kstate_q)
            K_IDLE, K_DONE: begin
                if (accept) begin
                    kstate_d       = K_RUN;
                    thread_count_d = launch.launch_thread_count;
                    total_d        = ceil_div_blocks(launch.launch_thread_count, TPB_LOG2);
                    disp_d         = '0;
                    ndone_d        = '0;
                end
            end
            K_RUN: begin
                if (abort) begin
                    kstate_d = K_IDLE;
                    for (int i = 0; i < NUM_CORES; i++) cstate_d[i] = C_IDLE;
                end else begin
                    if ((ndone_q == total_q) && all_idle) kstate_d = K_DONE;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (retire[i]) cstate_d[i] = C_IDLE;
                    end
                    ndone_d = ndone_q + ret_cnt;
                    if (grant_valid && (disp_q < total_q)) begin
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (grant[i]) begin
                                cstate_d[i] = C_RUN;
                                bid_d[i]    = disp_q;
                                tcnt_d[i]   = block_threads;
                            end
                        end
                        disp_d = disp_q + BLOCK_ID_W'(1);
                        rr_d   = (win == PW'(NUM_CORES - 1)) ? '0 : win + PW'(1);
                    end
                end
            end
            default: kstate_d = K_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kstate_q       <= K_IDLE;
            thread_count_q <= '0;
            total_q        <= '0;
            disp_q         <= '0;
            ndone_q        <= '0;
            rr_q           <= '0;
            bid_q          <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                cstate_q[i] <= C_IDLE;
                tcnt_q[i]   <= CW'(THREADS_PER_BLOCK);
            end
        end else begin
            kstate_q       <= kstate_d;
            cstate_q       <= cstate_d;
            thread_count_q <= thread_count_d;
            total_q        <= total_d;
            disp_q         <= disp_d;
            ndone_q        <= ndone_d;
            rr_q           <= rr_d;
            bid_q          <= bid_d;
            tcnt_q         <= tcnt_d;
        end
    end

    always_comb begin
        core_start = '0;
        core_reset = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_start[i] = (cstate_q[i] == C_RUN);
            core_reset[i] = (cstate_q[i] == C_IDLE);
        end
    end

    assign core_block_id     = bid_q;
    assign core_thread_count = tcnt_q;
    assign busy              = (kstate_q == K_RUN);
    assign done              = (kstate_q == K_DONE);

endmodule
